prio_arbiter: RTL and testbench
===============================

# prio_arbiter

Parametrised, registered priority arbiter. It selects one of `N_REQ` request lines and presents the winner as a binary index plus a one-hot grant, using a valid/ready handshake. Two modes: fixed priority (highest index wins) and round-robin with a rotating pointer. It sits between interrupt/request sources and a single shared consumer, and replaces the combinational priority encoder wherever fairness, backpressure or a registered output is needed.

## Interface
- `N_REQ`, default 8: number of request lines, must be ≥ 2, need not be a power of two.
- `IDX_W`, default `$clog2(N_REQ)`: width of the grant index.
- `clk`  in  1: single clock, rising edge.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `req`  in  `N_REQ`: request vector, level-sensitive, bit i = requester i.
- `mode`  in  1: 0 = fixed priority, 1 = round-robin.
- `grant_ready`  in  1: consumer accepts the current grant.
- `grant_valid`  out  1: a grant is presented.
- `grant_idx`  out  `IDX_W`: binary index of the granted requester.
- `grant_onehot`  out  `N_REQ`: one-hot form of `grant_idx`; all zero when not valid.

## Operation
- States:
  - IDLE: `grant_valid`=0.
  - GRANT: `grant_valid`=1, outputs frozen.
- Arbitration function, combinational, on `req` and the pointer `ptr` (width `IDX_W`):
  - Fixed: the highest set index wins. `ptr` is ignored.
  - RR: scan upward from `ptr` with wrap at `N_REQ-1`→0. The first set bit wins.
- IDLE → GRANT: at a rising edge where `req`≠0. The winner is registered into `grant_idx`/`grant_onehot`.
- GRANT, `grant_ready`=0: hold. Outputs stay stable even if `req` changes or drops (sticky grant). `mode` changes are ignored until acceptance.
- GRANT, `grant_ready`=1 (accept):
  - If in RR mode, `ptr` ← (`grant_idx`+1) mod `N_REQ`, so the just-granted requester becomes lowest priority.
  - If the arbitration of current `req` with the updated `ptr` is non-zero, stay in GRANT and load the new winner (back-to-back, one grant per cycle).
  - Otherwise go to IDLE.
- Mode is sampled only at IDLE→GRANT and at accept edges.
- In fixed mode `ptr` holds its value. Switching to RR resumes from the held `ptr`.
- `ptr` wrap: index `N_REQ-1` granted → `ptr`=0. Pointer values ≥ `N_REQ` never occur.
- `grant_ready` while `grant_valid`=0 has no effect.

## Timing
- Reset values:
  - `grant_valid`=0, `grant_idx`=0, `grant_onehot`=0.
  - `ptr`=0, state IDLE.
- Reset is applied asynchronously on the `rst_n` falling edge, including mid-grant. Outputs clear without waiting for `clk`.
- Request-to-grant latency: 1 cycle. `req` sampled at edge t gives `grant_valid` high after edge t.
- Accept-to-next-grant latency: 0 idle cycles. Sustained throughput is 1 grant/cycle with `grant_ready` held at 1.
- All outputs are registered. There is no combinational path from `req` or `grant_ready` to any output.

## Structure
- Package `arb_pkg`:
  - `MODE_FIXED`=1'b0 and `MODE_RR`=1'b1 constants.
  - State typedef `arb_state_t` {IDLE, GRANT}.
- Sub-module `pe_core`: parametrised combinational find-first-set with a rotate base input. It outputs `found`, index and one-hot. Instantiated once. The top holds the FSM, `ptr` and output registers.

## Test plan
All scenarios use `N_REQ`=8.
- Reset: `rst_n`=0, `req`=8'hFF, `grant_ready`=1 → `grant_valid`=0, `grant_idx`=0, `grant_onehot`=0 for the whole reset.
- Fixed priority: `mode`=0, `req`=8'b1000_0100, `grant_ready`=1 → `grant_idx`=7 every cycle from the cycle after `req` is applied. `req`=8'b0000_0011 → `grant_idx`=1.
- Round-robin fairness: `mode`=1, `req`=8'b1000_0100 held, `grant_ready`=1 → `grant_idx` sequence 2,7,2,7. With `req`=8'hFF the sequence is 0,1,…,7,0 (wrap).
- Backpressure, sticky grant: `mode`=0, `req`=8'b0010_0010, `grant_ready`=0 → `grant_idx`=5, `grant_onehot`=8'h20.
  - `req` then changes to 8'h01 → outputs unchanged while `grant_ready`=0.
  - Raise `grant_ready` for one cycle → next `grant_idx`=0.
- Idle and empty: `req`=0 → `grant_valid` stays 0. `req`=8'h10 at edge t → `grant_valid`=1 and `grant_idx`=4 after t. Accept with `req`=0 → `grant_valid`=0 the next cycle.
- Asynchronous reset mid-grant: RR mode, `ptr`=5, `grant_valid`=1.
  - Drop `rst_n` between edges → all outputs 0 immediately.
  - After release with `req`=8'hFF → first `grant_idx`=0.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared constants and types for the registered priority arbiter.
package arb_pkg;

   localparam logic MODE_FIXED = 1'b0;
   localparam logic MODE_RR    = 1'b1;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } arb_state_t;

endpackage

// File: rtl/pe_core.sv
// Combinational find-first-set: highest index in fixed mode, or first set bit
// scanning upward from a rotate base (with wrap) in round-robin mode.
module pe_core #(
   parameter int N = 8,
   parameter int W = $clog2(N)
) (
   input  logic [N-1:0] req,
   input  logic [W-1:0] base,
   input  logic         rr,
   output logic         found,
   output logic [W-1:0] idx,
   output logic [N-1:0] onehot
);
   import arb_pkg::*;

   logic [2*N-1:0] dbl;
   logic [N-1:0]   rot;
   int             s;

   always_comb begin
      found = 1'b0;
      idx   = '0;
      s     = 0;
      dbl   = {req, req} >> base;
      rot   = dbl[N-1:0];
      if (rr == MODE_FIXED) begin
         for (int i = 0; i < N; i++) begin
            if (req[i]) begin
               found = 1'b1;
               idx   = W'(i);
            end
         end
      end else begin
         // rot[k] is requester (base+k) mod N; scanning down leaves the lowest k.
         for (int k = N - 1; k >= 0; k--) begin
            if (rot[k]) begin
               s = int'(base) + k;
               if (s >= N) s = s - N;
               found = 1'b1;
               idx   = W'(s);
            end
         end
      end
      onehot = found ? (N'(1) << idx) : '0;
   end

endmodule

// File: rtl/prio_arbiter.sv
// Registered priority arbiter, fixed or round-robin, with a sticky grant held
// until grant_ready. Handshake: a grant transfers on a rising edge where
// grant_valid && grant_ready; while grant_valid && !grant_ready outputs are frozen.
module prio_arbiter #(
   parameter int N_REQ = 8,
   parameter int IDX_W = $clog2(N_REQ)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [N_REQ-1:0] req,
   input  logic             mode,
   input  logic             grant_ready,
   output logic             grant_valid,
   output logic [IDX_W-1:0] grant_idx,
   output logic [N_REQ-1:0] grant_onehot
);
   import arb_pkg::*;

   arb_state_t       state_q, state_d;
   logic [IDX_W-1:0] ptr_q, ptr_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [N_REQ-1:0] onehot_q, onehot_d;

   logic             accept;
   logic [IDX_W-1:0] base;
   logic             win_found;
   logic [IDX_W-1:0] win_idx;
   logic [N_REQ-1:0] win_onehot;

   pe_core #(
      .N (N_REQ),
      .W (IDX_W)
   ) u_pe_core (
      .req    (req),
      .base   (base),
      .rr     (mode),
      .found  (win_found),
      .idx    (win_idx),
      .onehot (win_onehot)
   );

   always_comb begin
      state_d  = state_q;
      ptr_d    = ptr_q;
      idx_d    = idx_q;
      onehot_d = onehot_q;
      accept   = (state_q == GRANT) && grant_ready;
      base     = ptr_q;
      // On accept in RR the arbitration already sees the advanced pointer.
      if (accept && (mode == MODE_RR)) begin
         base = (idx_q == IDX_W'(N_REQ - 1)) ? '0 : idx_q + IDX_W'(1);
      end
      case (state_q)
         IDLE: begin
            if (win_found) begin
               state_d  = GRANT;
               idx_d    = win_idx;
               onehot_d = win_onehot;
            end
         end
         GRANT: begin
            if (accept) begin
               ptr_d = base;
               if (win_found) begin
                  idx_d    = win_idx;
                  onehot_d = win_onehot;
               end else begin
                  state_d  = IDLE;
                  onehot_d = '0;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         ptr_q    <= '0;
         idx_q    <= '0;
         onehot_q <= '0;
      end else begin
         state_q  <= state_d;
         ptr_q    <= ptr_d;
         idx_q    <= idx_d;
         onehot_q <= onehot_d;
      end
   end

   assign grant_valid  = (state_q == GRANT);
   assign grant_idx    = idx_q;
   assign grant_onehot = onehot_q;

endmodule

// File: tb/tb_prio_arbiter.sv
// Bench for prio_arbiter: directed scenarios plus random traffic, all compared
// against a behavioural model of the arbitration rules.
module tb_prio_arbiter;
   localparam int N = 8;
   localparam int W = 3;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic [N-1:0] req = '0;
   logic         mode = 1'b0;
   logic         grant_ready = 1'b0;
   logic         grant_valid;
   logic [W-1:0] grant_idx;
   logic [N-1:0] grant_onehot;

   int checks = 0;
   int errors = 0;
   bit cmp_en = 1'b0;

   logic m_valid = 1'b0;
   int   m_idx = 0;
   int   m_ptr = 0;

   prio_arbiter #(.N_REQ(N), .IDX_W(W)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .req          (req),
      .mode         (mode),
      .grant_ready  (grant_ready),
      .grant_valid  (grant_valid),
      .grant_idx    (grant_idx),
      .grant_onehot (grant_onehot)
   );

   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   function automatic int arb(logic [N-1:0] r, int p, logic m);
      if (!m) begin
         for (int i = N - 1; i >= 0; i--)
            if (((r >> i) & 1) != 0) return i;
      end else begin
         for (int k = 0; k < N; k++) begin
            int j;
            j = (p + k) % N;
            if (((r >> j) & 1) != 0) return j;
         end
      end
      return -1;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      int w;
      if (!rst_n) begin
         m_valid = 1'b0;
         m_idx   = 0;
         m_ptr   = 0;
      end else if (!m_valid) begin
         w = arb(req, m_ptr, mode);
         if (w >= 0) begin
            m_valid = 1'b1;
            m_idx   = w;
         end
      end else if (grant_ready) begin
         if (mode) m_ptr = (m_idx + 1) % N;
         w = arb(req, m_ptr, mode);
         if (w >= 0) m_idx = w;
         else m_valid = 1'b0;
      end
   end

   // ---------------- scoreboard ----------------
   task automatic chk(string name, int act, int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (cmp_en) begin
         #1;
         chk("model_valid", int'(grant_valid), int'(m_valid));
         if (m_valid) chk("model_idx", int'(grant_idx), m_idx);
         chk("model_onehot", int'(grant_onehot), m_valid ? (1 << m_idx) : 0);
      end
   end

   // ---------------- driver ----------------
   task automatic tick();
      @(negedge clk);
      #2;
   endtask

   task automatic chk_zero(string tag);
      chk({tag, "_valid"}, int'(grant_valid), 0);
      chk({tag, "_idx"}, int'(grant_idx), 0);
      chk({tag, "_onehot"}, int'(grant_onehot), 0);
   endtask

   initial begin
      int rr_a[4];
      rr_a = '{2, 7, 2, 7};

      // Reset held with every request active and the consumer ready.
      rst_n = 1'b0; req = 8'hFF; grant_ready = 1'b1; mode = 1'b0;
      repeat (3) begin
         tick();
         chk_zero("reset");
      end
      cmp_en = 1'b1;
      tick();
      rst_n = 1'b1; req = 8'h00;
      tick();

      // Fixed priority.
      req = 8'b1000_0100; mode = 1'b0; grant_ready = 1'b1;
      repeat (3) begin
         tick();
         chk("fixed_valid", int'(grant_valid), 1);
         chk("fixed_idx_hi", int'(grant_idx), 7);
      end
      req = 8'b0000_0011;
      tick();
      chk("fixed_idx_lo", int'(grant_idx), 1);
      req = 8'h00;
      tick();
      chk("fixed_to_idle", int'(grant_valid), 0);

      // Round-robin fairness, then full wrap.
      mode = 1'b1; req = 8'b1000_0100;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("rr_pair", int'(grant_idx), rr_a[i]);
      end
      req = 8'h00;
      tick();
      chk("rr_idle", int'(grant_valid), 0);
      req = 8'hFF;
      for (int i = 0; i < 9; i++) begin
         tick();
         chk("rr_wrap", int'(grant_idx), i % N);
      end
      req = 8'h00;
      tick();

      // Backpressure with a sticky grant.
      mode = 1'b0; req = 8'b0010_0010; grant_ready = 1'b0;
      tick();
      chk("bp_idx", int'(grant_idx), 5);
      chk("bp_onehot", int'(grant_onehot), 8'h20);
      req = 8'h01;
      repeat (2) begin
         tick();
         chk("sticky_idx", int'(grant_idx), 5);
         chk("sticky_onehot", int'(grant_onehot), 8'h20);
      end
      grant_ready = 1'b1;
      tick();
      grant_ready = 1'b0;
      chk("bp_next_idx", int'(grant_idx), 0);
      req = 8'h00; grant_ready = 1'b1;
      tick();
      chk("bp_drain", int'(grant_valid), 0);

      // Idle and empty.
      repeat (2) begin
         tick();
         chk("empty_valid", int'(grant_valid), 0);
      end
      req = 8'h10;
      tick();
      chk("single_valid", int'(grant_valid), 1);
      chk("single_idx", int'(grant_idx), 4);
      req = 8'h00;
      tick();
      chk("accept_empty", int'(grant_valid), 0);

      // Asynchronous reset mid-grant with the RR pointer at 5.
      mode = 1'b1; req = 8'h10; grant_ready = 1'b1;
      tick();
      chk("pre_rst_idx4", int'(grant_idx), 4);
      req = 8'h20;
      tick();
      grant_ready = 1'b0;
      chk("pre_rst_idx5", int'(grant_idx), 5);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk_zero("async_rst");
      tick();
      rst_n = 1'b1; req = 8'hFF; grant_ready = 1'b1;
      tick();
      chk("post_rst_idx", int'(grant_idx), 0);

      // Random traffic with occasional mid-cycle resets.
      repeat (3000) begin
         tick();
         req = N'($urandom_range(0, 255));
         if ($urandom_range(0, 3) == 0) req = '0;
         if ($urandom_range(0, 7) == 0) mode = ~mode;
         grant_ready = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 199) == 0) begin
            #1 rst_n = 1'b0;
            #1;
            chk("rand_rst_valid", int'(grant_valid), 0);
            rst_n = 1'b1;
         end
      end
      tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
